// File: rtl/spm_pkg.sv
// Shared types and width helpers for the serial-parallel multiplier.
package spm_pkg;

  // Control states of the multiplier sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spm_state_e;

  // Product width: twice the operand width, so the result is always exact.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

  // Bit-counter width: large enough to hold 2*WIDTH without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(2 * width + 1);
  endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One-bit serial carry-save adder cell of the serial-parallel multiplier.
// Adds the partial-product bit x_bit&y_bit, the sum arriving from the next
// more significant cell and this cell's own stored carry. The sum is passed
// down to the less significant neighbour on the next edge; the carry stays
// here, because after the per-cycle right shift it lands on this cell's weight.
// With mode=1 (signed MSB cell) the partial-product bit is inverted and the
// carry is preset to 1 on clear; together these turn the negative-weight
// MSB term into an all-positive sum that is exact modulo 2^(2*WIDTH).
module spm_csa_cell (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic mode,
  input  logic x_bit,
  input  logic y_bit,
  input  logic sum_in,
  output logic sum_q,
  output logic sum_d
);

  logic pp;
  logic carry_q;
  logic carry_d;

  // Full-adder combination of partial product, incoming sum and stored carry.
  always_comb begin
    pp      = (x_bit & y_bit) ^ mode;
    sum_d   = pp ^ sum_in ^ carry_q;
    carry_d = (pp & sum_in) | (pp & carry_q) | (sum_in & carry_q);
  end

  // Sum and carry flops: cleared (carry preset to mode) at operation start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else if (clear) begin
      sum_q   <= 1'b0;
      carry_q <= mode;
    end else if (en) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/spm_seq_mult.sv
// Sequential serial-parallel multiplier with start/busy/done handshake.
// x is held in parallel across a row of carry-save cells; y is extended to
// 2*WIDTH bits and fed LSB-first. One product bit leaves cell 0 per edge and
// is shifted into an accumulation register, copied to p on completion.
module spm_seq_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  spm_state_e      state_q;
  spm_state_e      state_d;
  logic            load;
  logic            finish;

  logic [WIDTH-1:0] x_q;
  logic             sgn_q;
  logic [PW-1:0]    y_sr;
  logic [PW-1:0]    y_ext;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    p_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q_vec;
  logic [WIDTH-1:0] sum_d_vec;
  logic             prod_bit;
  logic             unused_bits;

  // Multiplier extended to product width according to the requested mode.
  assign y_ext = {{WIDTH{sgn & y[WIDTH-1]}}, y};

  // The product bit of the current cycle is cell 0's combinational sum.
  assign prod_bit = sum_d_vec[0];

  // Cell 0's stored sum and the upper cells' combinational sums only feed the
  // chain internally; the bit shifted out of acc is already held in p's LSBs.
  assign unused_bits = ^{sum_q_vec[0], sum_d_vec[WIDTH-1:1], acc[0]};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(PW - 1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign p    = p_q;

  // Operand latch, multiplier shift register, bit counter and product capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      sgn_q <= 1'b0;
      y_sr  <= '0;
      acc   <= '0;
      p_q   <= '0;
      cnt   <= '0;
    end else if (load) begin
      x_q   <= x;
      sgn_q <= sgn;
      y_sr  <= y_ext;
      acc   <= '0;
      cnt   <= '0;
    end else if (state_q == RUN) begin
      y_sr <= {1'b0, y_sr[PW-1:1]};
      acc  <= {prod_bit, acc[PW-1:1]};
      cnt  <= cnt + CW'(1);
      if (finish) begin
        p_q <= {prod_bit, acc[PW-1:1]};
      end
    end
  end

  // Carry-save row: cell gi receives the stored sum of cell gi+1.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    logic sum_in;
    logic mode;
    if (gi == WIDTH - 1) begin : g_msb
      // The clear on the accepting edge must see the mode being latched now.
      assign sum_in = 1'b0;
      assign mode   = load ? sgn : sgn_q;
    end else begin : g_body
      assign sum_in = sum_q_vec[gi+1];
      assign mode   = 1'b0;
    end

    spm_csa_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .clear  (load),
      .en     (busy),
      .mode   (mode),
      .x_bit  (x_q[gi]),
      .y_bit  (y_sr[0]),
      .sum_in (sum_in),
      .sum_q  (sum_q_vec[gi]),
      .sum_d  (sum_d_vec[gi])
    );
  end

endmodule

// File: tb/tb_spm_seq_mult.sv
// Self-checking bench for spm_seq_mult at WIDTH=8 and WIDTH=4.
module tb_spm_seq_mult;

  logic        clk;
  logic        rst;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;

  logic        start4, sgn4, busy4, done4;
  logic [3:0]  x4, y4;
  logic [7:0]  p4;

  int n_checks;
  int n_fail;

  spm_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .p(p8)
  );

  spm_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2*w bits.
  function automatic logic [63:0] ref_mult(input int w, input bit s,
                                           input logic [31:0] a, input logic [31:0] b);
    longint av, bv, pr;
    logic [63:0] r;
    av = longint'(a & ((32'd1 << w) - 1));
    bv = longint'(b & ((32'd1 << w) - 1));
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    pr = av * bv;
    r  = pr;
    return r & ((64'd1 << (2 * w)) - 1);
  endfunction

  // One WIDTH=8 operation with input noise during the run.
  task automatic run8(input string tag, input bit s, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp);
    int lat;
    int busy_cycles;
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; x8 = a; y8 = b;
    @(posedge clk); #1;
    busy_cycles = (busy8 === 1'b1) ? 1 : 0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      start8 = (lat < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      x8 = 8'($urandom); y8 = 8'($urandom); sgn8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (done8 !== 1'b1 && busy8 === 1'b1) busy_cycles++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd16);
    check({tag, "_busycyc"}, 64'(busy_cycles), 64'd16);
    check({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
    check({tag, "_p"}, 64'(p8), 64'(exp));
    $display("txn w8 %s sgn=%0d x=%02h y=%02h p=%04h exp=%04h lat=%0d", tag, s, a, b, p8, exp, lat);
    start8 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done8), 64'd0);
    check({tag, "_p_hold"}, 64'(p8), 64'(exp));
  endtask

  // One WIDTH=4 operation.
  task automatic run4(input string tag, input bit s, input logic [3:0] a,
                      input logic [3:0] b, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    start4 = 1'b1; sgn4 = s; x4 = a; y4 = b;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      x4 = 4'($urandom); y4 = 4'($urandom); sgn4 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_p"}, 64'(p4), 64'(exp));
    $display("txn w4 %s sgn=%0d x=%01h y=%01h p=%02h exp=%02h lat=%0d", tag, s, a, b, p4, exp, lat);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done4), 64'd0);
  endtask

  // start held high: each done is followed immediately by the next acceptance.
  task automatic b2b8(input int n);
    logic [15:0] exp_q[$];
    logic [15:0] e;
    int lat;
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_q.push_back(16'(ref_mult(8, sgn8, 32'(x8), 32'(y8))));
      check("b2b_busy", 64'(busy8), 64'd1);
      check("b2b_done_low", 64'(done8), 64'd0);
      sgn8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      e = exp_q.pop_front();
      check("b2b_lat", 64'(lat), 64'd16);
      check("b2b_p", 64'(p8), 64'(e));
      $display("txn w8 b2b k=%0d p=%04h exp=%04h lat=%0d", k, p8, e, lat);
    end
    start8 = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle", 64'(busy8 | done8), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    start8 = 1'b0; sgn8 = 1'b0; x8 = '0; y8 = '0;
    start4 = 1'b0; sgn4 = 1'b0; x4 = '0; y4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_p", 64'(p8), 64'd0);
    check("rst_p4", 64'(p4), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with hand-computed products.
    run8("s_3x5",      1'b1, 8'h03, 8'h05, 16'h000F);
    run8("s_m3x5",     1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run8("s_minxmin",  1'b1, 8'h80, 8'h80, 16'h4000);
    run8("s_m1xm1",    1'b1, 8'hFF, 8'hFF, 16'h0001);
    run8("u_ffxff",    1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("u_80x02",    1'b0, 8'h80, 8'h02, 16'h0100);

    // Randomised cases against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      logic s;
      logic [7:0] a, b;
      s = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      run8("rnd8", s, a, b, 16'(ref_mult(8, s, 32'(a), 32'(b))));
    end

    b2b8(4);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    start8 = 1'b1; sgn8 = 1'b0; x8 = 8'h5A; y8 = 8'hC3;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_p", 64'(p8), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run8("after_abort", 1'b0, 8'h5A, 8'hC3, 16'(ref_mult(8, 1'b0, 32'h5A, 32'hC3)));

    // WIDTH=4 instance.
    run4("s_m8x7",  1'b1, 4'h8, 4'h7, 8'hC8);
    run4("u_fxf",   1'b0, 4'hF, 4'hF, 8'hE1);
    for (int i = 0; i < 8; i++) begin
      logic s;
      logic [3:0] a, b;
      s = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
      run4("rnd4", s, a, b, 8'(ref_mult(4, s, 32'(a), 32'(b))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_seq_mult.md
Name: spm_seq_mult

Overview:
- Parametrised sequential serial-parallel multiplier, the next generation of the fixed 8x8 signed SPM datapath.
- Multiplicand x is applied in parallel to a row of carry-save cells. Multiplier y is sign- or zero-extended to 2*WIDTH bits and shifted in LSB-first.
- Adds a start/busy/done handshake, a run-time signed/unsigned mode, and a parallel 2*WIDTH-bit product register.
- Sits between the operand source and any consumer of the full-width product.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; latched on start acceptance.
- x  in  WIDTH  multiplicand; latched on start acceptance.
- y  in  WIDTH  multiplier; latched on start acceptance.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  single-cycle pulse; p valid from that cycle on.
- p  out  2*WIDTH  product; holds its value until the next completion or reset.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, p=0, all CSA sum/carry flops=0, shift register=0, bit counter=0. Reset asserted mid-operation aborts immediately. No partial product reaches p.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: latch x, y, sgn. Load the 2*WIDTH shift register with y extended (sign-extended if sgn=1, zero-extended if sgn=0). Clear the CSA array and counter. Go to RUN; busy=1 from this edge.
  - RUN: each edge shifts one y bit into the array and one product bit (LSB first) into the p accumulation register. Counter increments each edge.
  - RUN, after 2*WIDTH edges: go to DONE. Update p with the accumulated 2*WIDTH bits. busy=0, done=1 for exactly that cycle.
  - DONE, next edge: start=1 is accepted exactly as from IDLE (back-to-back operation); otherwise go to IDLE. done=0 in both cases.
- Latency: done is high 2*WIDTH clock cycles after the start-acceptance edge. Throughput is one product per 2*WIDTH+1 cycles with start held high.
- start while busy=1 is ignored. Changes to x, y, sgn during RUN have no effect.
- Arithmetic:
  - p equals the exact product; no truncation and no overflow is possible.
  - Signed mode: the MSB cell of x uses two's-complement (negating) handling, so most-negative times most-negative is exact, e.g. WIDTH=8: -128 * -128 = 0x4000.
  - Unsigned mode: the MSB cell behaves as a normal CSA cell.
- Counter width is clog2(2*WIDTH+1). The counter does not wrap during RUN; its terminal compare is exactly 2*WIDTH-1.
- p register is written only on RUN->DONE. Between operations p holds its value.

Decomposition:
- Shared package spm_pkg:
  - state enum (IDLE, RUN, DONE).
  - function computing counter width from WIDTH.
  - product-width constant expression 2*WIDTH.
- Sub-module spm_csa_cell: one-bit serial carry-save adder with sum and carry flops, async active-low reset, and a mode input selecting normal or two's-complement (MSB) behaviour.
- Top instantiates WIDTH spm_csa_cell copies via generate.

Test Plan:
- WIDTH=8, sgn=1, x=3, y=5, start pulse -> busy for 16 cycles, done pulse on cycle 16, p=0x000F.
- WIDTH=8, sgn=1: x=0xFD (-3), y=5 -> p=0xFFF1. Then x=0x80, y=0x80 -> p=0x4000. Then x=0xFF, y=0xFF -> p=0x0001.
- WIDTH=8, sgn=0: x=0xFF, y=0xFF -> p=0xFE01. Then x=0x80, y=0x02 -> p=0x0100.
- start held high continuously with changing operands -> done every 17 cycles, each p correct. start and operand changes during busy are ignored.
- Drive rst low at cycle 7 of a run -> busy=0, done=0, p=0 immediately. A new start after release gives the correct product.
- WIDTH=4, sgn=1: x=0x8 (-8), y=0x7 -> done after 8 cycles, p=0xC8. Also sgn=0, x=0xF, y=0xF -> p=0xE1.
